// File: rtl/alu_pkg.sv
// Shared encodings for the accumulator ALU: op codes, FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one multiplier bit per clock for DATA_W clocks, then a
// one-cycle done pulse with the full 2*DATA_W product held on product.
module alu_mul_seq #(
  parameter int DATA_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [2*DATA_W-1:0] r_mcand;
  logic [2*DATA_W-1:0] r_prod;
  logic [DATA_W-1:0]   r_mplier;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_run;
  logic                r_done;
  logic [2*DATA_W-1:0] w_addend;

  assign w_addend = r_mplier[0] ? r_mcand : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start && !r_run) begin
        r_mcand  <= {{DATA_W{1'b0}}, a};
        r_mplier <= b;
        r_prod   <= '0;
        r_cnt    <= '0;
        r_run    <= 1'b1;
      end else if (r_run) begin
        r_prod   <= r_prod + w_addend;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done    = r_done;
  assign product = r_prod;

endmodule

// File: rtl/alu_accumulator.sv
// Accumulator ALU with a shared tri-state databus. Define ALU_MUL_EN to add the
// sequential multiplier (op 111, product_hi); otherwise op 111 is a one-cycle NOP.
module alu_accumulator
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] operand,
  inout  wire  [DATA_W-1:0] databus,
  input  logic [2:0]        op,
  input  logic              start,
  input  logic              acc_load,
  input  logic              out_enable,
  output logic [DATA_W-1:0] acc_value,
  output logic [3:0]        flags,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product_hi
);
  localparam int MSB = DATA_W - 1;

  state_e            r_state;
  state_e            w_state_next;
  op_e               r_op;
  logic [DATA_W-1:0] r_operand;
  logic [DATA_W-1:0] r_acc;
  logic [3:0]        r_flags;
  logic              r_done;

  logic              w_accept;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_res;
  logic [3:0]        w_flags;
  logic              w_carry;
  logic              w_ovf;
  logic              w_write;

  // acc_load has priority over start, so a simultaneous start is dropped.
  assign w_accept = (r_state == S_IDLE) && start && !acc_load;

`ifdef ALU_MUL_EN
  logic                w_mul_start;
  logic                w_mul_done;
  logic [2*DATA_W-1:0] w_mul_prod;
  logic [DATA_W-1:0]   r_prod_hi;

  assign w_mul_start = w_accept && (op == OP_MUL);

  alu_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (w_mul_start),
    .a       (r_acc),
    .b       (operand),
    .done    (w_mul_done),
    .product (w_mul_prod)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prod_hi <= '0;
    end else if (r_state == S_MUL && w_mul_done) begin
      r_prod_hi <= w_mul_prod[2*DATA_W-1:DATA_W];
    end
  end

  assign product_hi = r_prod_hi;
`else
  assign product_hi = '0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef ALU_MUL_EN
          w_state_next = (op == OP_MUL) ? S_MUL : S_EXEC;
`else
          w_state_next = S_EXEC;
`endif
        end
      end
      S_EXEC: w_state_next = S_IDLE;
`ifdef ALU_MUL_EN
      S_MUL: begin
        if (w_mul_done) w_state_next = S_IDLE;
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_sum  = {1'b0, r_acc} + {1'b0, r_operand};
  assign w_diff = {1'b0, r_acc} - {1'b0, r_operand};

  always_comb begin
    w_res   = r_acc;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_write = 1'b1;
    case (r_op)
      OP_ADD: begin
        w_res   = w_sum[MSB:0];
        w_carry = w_sum[DATA_W];
        w_ovf   = (r_acc[MSB] == r_operand[MSB]) && (w_sum[MSB] != r_acc[MSB]);
      end
      OP_SUB: begin
        // Zero-extended subtraction leaves the borrow in the extra top bit.
        w_res   = w_diff[MSB:0];
        w_carry = w_diff[DATA_W];
        w_ovf   = (r_acc[MSB] != r_operand[MSB]) && (w_diff[MSB] != r_acc[MSB]);
      end
      OP_AND: w_res = r_acc & r_operand;
      OP_OR:  w_res = r_acc | r_operand;
      OP_XOR: w_res = r_acc ^ r_operand;
      OP_SHL: begin
        w_res   = {r_acc[MSB-1:0], 1'b0};
        w_carry = r_acc[MSB];
      end
      OP_SHR: begin
        w_res   = {1'b0, r_acc[MSB:1]};
        w_carry = r_acc[0];
      end
      default: w_write = 1'b0;
    endcase
    w_flags         = r_flags;
    w_flags[FLAG_Z] = (w_res == '0);
    w_flags[FLAG_N] = w_res[MSB];
    w_flags[FLAG_C] = w_carry;
    w_flags[FLAG_V] = w_ovf;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= OP_ADD;
      r_operand <= '0;
      r_acc     <= '0;
      r_flags   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      if (r_state == S_IDLE && acc_load) begin
        r_acc <= databus;
      end
      if (w_accept) begin
        r_op      <= op_e'(op);
        r_operand <= operand;
      end
      if (r_state == S_EXEC) begin
        r_done <= 1'b1;
        if (w_write) begin
          r_acc   <= w_res;
          r_flags <= w_flags;
        end
      end
`ifdef ALU_MUL_EN
      if (r_state == S_MUL && w_mul_done) begin
        r_done          <= 1'b1;
        r_acc           <= w_mul_prod[MSB:0];
        r_flags[FLAG_Z] <= (w_mul_prod == '0);
        r_flags[FLAG_N] <= w_mul_prod[MSB];
        r_flags[FLAG_C] <= (w_mul_prod[2*DATA_W-1:DATA_W] != '0);
        r_flags[FLAG_V] <= (w_mul_prod[2*DATA_W-1:DATA_W] != '0);
      end
`endif
    end
  end

  assign databus   = out_enable ? r_acc : {DATA_W{1'bz}};
  assign acc_value = r_acc;
  assign flags     = r_flags;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_alu_accumulator.sv
// Self-checking bench for alu_accumulator: directed corner cases followed by
// randomized ops checked against an arithmetic reference model.
module tb_alu_accumulator;
  localparam int W    = 8;
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clock      = 1'b0;
  logic         reset      = 1'b1;
  logic [W-1:0] operand    = '0;
  logic [2:0]   op         = '0;
  logic         start      = 1'b0;
  logic         acc_load   = 1'b0;
  logic         out_enable = 1'b0;
  logic         tb_en      = 1'b0;
  logic [W-1:0] tb_val     = '0;
  wire  [W-1:0] databus;
  logic [W-1:0] acc_value;
  logic [W-1:0] product_hi;
  logic [3:0]   flags;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;
  int m_acc    = 0;
  int m_flags  = 0;
  int m_hi     = 0;

  assign databus = tb_en ? tb_val : {W{1'bz}};

  always #5 clock = ~clock;

  alu_accumulator #(.DATA_W(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .operand    (operand),
    .databus    (databus),
    .op         (op),
    .start      (start),
    .acc_load   (acc_load),
    .out_enable (out_enable),
    .acc_value  (acc_value),
    .flags      (flags),
    .busy       (busy),
    .done       (done),
    .product_hi (product_hi)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned/signed interpretations.
  function automatic void model(input int opc, input int a, input int b, input int fl_in,
                                input int hi_in, output int res, output int fl,
                                output int hi, output int lat);
    int s, sa, sb, p, c, v;
    sa  = (a >= HALF) ? a - FULL : a;
    sb  = (b >= HALF) ? b - FULL : b;
    c   = 0;
    v   = 0;
    res = a;
    fl  = fl_in;
    hi  = hi_in;
    lat = 1;
    if (opc == 7) begin
`ifdef ALU_MUL_EN
      p   = a * b;
      res = p % FULL;
      hi  = p / FULL;
      lat = W + 1;
      fl  = ((hi != 0) ? 8 : 0) + ((res >= HALF) ? 4 : 0) + ((hi != 0) ? 2 : 0) + ((p == 0) ? 1 : 0);
`endif
    end else begin
      case (opc)
        0: begin
          s   = a + b;
          res = s % FULL;
          c   = (s >= FULL) ? 1 : 0;
          s   = sa + sb;
          v   = (s >= HALF || s < -HALF) ? 1 : 0;
        end
        1: begin
          res = (a - b + FULL) % FULL;
          c   = (a < b) ? 1 : 0;
          s   = sa - sb;
          v   = (s >= HALF || s < -HALF) ? 1 : 0;
        end
        2: res = a & b;
        3: res = a | b;
        4: res = a ^ b;
        5: begin
          res = (a * 2) % FULL;
          c   = (a >= HALF) ? 1 : 0;
        end
        default: begin
          res = a / 2;
          c   = a % 2;
        end
      endcase
      fl = v * 8 + ((res >= HALF) ? 4 : 0) + c * 2 + ((res == 0) ? 1 : 0);
    end
  endfunction

  task automatic load(input int v);
    out_enable = 1'b0;
    tb_en      = 1'b1;
    tb_val     = W'(v);
    acc_load   = 1'b1;
    @(posedge clock); #1;
    acc_load = 1'b0;
    tb_en    = 1'b0;
    m_acc    = v;
    check("load_acc", acc_value, m_acc);
    check("load_flags_kept", flags, m_flags);
    check("load_busy", busy, 0);
  endtask

  task automatic run_op(input int opc, input int b, input int oe, input int inject);
    int  res, fl, hi, lat, cycles, old_acc;
    bit  got;
    model(opc, m_acc, b, m_flags, m_hi, res, fl, hi, lat);
    old_acc    = m_acc;
    op         = opc[2:0];
    operand    = W'(b);
    out_enable = (oe != 0);
    start      = 1'b1;
    @(posedge clock); #1;
    start   = 1'b0;
    operand = W'($urandom);
    op      = 3'($urandom);
    check("busy_after_accept", busy, 1);
    check("done_after_accept", done, 0);
    if (inject != 0) begin
      start = 1'b1;
      op    = 3'b000;
      if (oe == 0) begin
        acc_load = 1'b1;
        tb_en    = 1'b1;
        tb_val   = W'(old_acc ^ 'h5A);
      end
    end
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 40) begin
      @(posedge clock); #1;
      cycles++;
      start    = 1'b0;
      acc_load = 1'b0;
      tb_en    = 1'b0;
      if (done) got = 1'b1;
      else check("busy_while_running", busy, 1);
      if (oe != 0) check("bus_follows_acc", databus, got ? res : old_acc);
    end
    check("done_seen", got, 1);
    check("latency", cycles, lat);
    check("busy_at_done", busy, 0);
    check("acc", acc_value, res);
    check("flags", flags, fl);
    check("product_hi", product_hi, hi);
    $display("op=%0d a=%02h b=%02h -> acc=%02h flags=%h hi=%02h lat=%0d",
             opc, old_acc, b, acc_value, flags, product_hi, cycles);
    m_acc   = res;
    m_flags = fl;
    m_hi    = hi;
    @(posedge clock); #1;
    check("done_single_pulse", done, 0);
    out_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_acc", acc_value, 0);
    check("rst_flags", flags, 0);
    check("rst_hi", product_hi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    out_enable = 1'b1;
    #1;
    check("rst_bus_driven", databus, 0);
    out_enable = 1'b0;
    reset      = 1'b0;
    @(posedge clock); #1;

    // ADD overflow into the sign bit
    load('h7F);
    run_op(0, 'h01, 0, 0);
    check("add_acc_const", acc_value, 'h80);
    check("add_flags_const", flags, 'hC);

    // SUB to zero, then borrow
    load('h05);
    run_op(1, 'h05, 1, 0);
    check("sub_zero_flags", flags, 'h1);
    run_op(1, 'h01, 0, 1);
    check("sub_borrow_acc", acc_value, 'hFF);
    check("sub_borrow_flags", flags, 'h6);

    // Shifts
    load('h81);
    run_op(5, $urandom_range(0, FULL - 1), 0, 0);
    check("shl_acc_const", acc_value, 'h02);
    check("shl_flags_const", flags, 'h2);
    run_op(6, $urandom_range(0, FULL - 1), 1, 0);
    check("shr_acc_const", acc_value, 'h01);

`ifdef ALU_MUL_EN
    load('h10);
    run_op(7, 'h20, 1, 1);
    check("mul_acc_const", acc_value, 'h00);
    check("mul_hi_const", product_hi, 'h02);
    check("mul_flags_const", flags, 'hA);

    // Reset in the fourth multiply cycle aborts without done
    load('h37);
    op      = 3'b111;
    operand = W'('h9B);
    start   = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      check("mul_abort_no_done_pre", done, 0);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_acc", acc_value, 0);
    check("abort_flags", flags, 0);
    check("abort_hi", product_hi, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset = 1'b0;
    m_acc = 0; m_flags = 0; m_hi = 0;
    repeat (12) begin
      @(posedge clock); #1;
      check("abort_no_done", done, 0);
    end
`else
    load('h3C);
    run_op(7, 'h55, 0, 1);
    check("nop_acc_const", acc_value, 'h3C);
    check("nop_hi_const", product_hi, 0);
`endif

    // Reset during EXEC
    load('h42);
    op      = 3'b000;
    operand = W'('h01);
    start   = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    check("exec_abort_done", done, 0);
    check("exec_abort_acc", acc_value, 0);
    check("exec_abort_busy", busy, 0);
    reset = 1'b0;
    m_acc = 0; m_flags = 0; m_hi = 0;
    repeat (3) begin
      @(posedge clock); #1;
      check("exec_abort_no_done", done, 0);
    end

    // acc_load beats start in IDLE
    tb_en    = 1'b1;
    tb_val   = W'('hA5);
    acc_load = 1'b1;
    start    = 1'b1;
    op       = 3'b000;
    operand  = W'('h01);
    @(posedge clock); #1;
    acc_load = 1'b0;
    start    = 1'b0;
    tb_en    = 1'b0;
    m_acc    = 'hA5;
    check("prio_acc", acc_value, 'hA5);
    check("prio_busy", busy, 0);
    @(posedge clock); #1;
    check("prio_no_done", done, 0);
    check("prio_acc_hold", acc_value, 'hA5);

    // Bus released when out_enable is low
    out_enable = 1'b0;
    tb_en      = 1'b1;
    tb_val     = W'('h5A);
    #1;
    check("bus_hiz_5a", databus, 'h5A);
    tb_val = W'('hC3);
    #1;
    check("bus_hiz_c3", databus, 'hC3);
    tb_en      = 1'b0;
    out_enable = 1'b1;
    #1;
    check("bus_drive_acc", databus, m_acc);
    out_enable = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) load($urandom_range(0, FULL - 1));
      run_op($urandom_range(0, 7), $urandom_range(0, FULL - 1),
             $urandom_range(0, 1), ($urandom_range(0, 4) == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_accumulator.md
ALU_ACCUMULATOR -- requirements
Module: alu_accumulator

Interface
REQ-001 Parameter DATA_W, default 8: data path width of operand, accumulator and databus.
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clock.
REQ-004 operand  input  DATA_W  operand B, driven by the register file ALU read port.
REQ-005 databus  inout  DATA_W  shared CPU data bus; accumulator source and sink.
REQ-006 op  input  3  operation select, sampled with start.
REQ-007 start  input  1  active-high request to execute op.
REQ-008 acc_load  input  1  active-high load of accumulator from databus.
REQ-009 out_enable  input  1  active-high drive of accumulator onto databus.
REQ-010 acc_value  output  DATA_W  current accumulator contents.
REQ-011 flags  output  4  {V,N,C,Z}, bit 3 to bit 0.
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 done  output  1  single-cycle pulse marking operation completion.
REQ-014 product_hi  output  DATA_W  upper half of last multiply result.

Function
REQ-015 Op codes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
REQ-016 FSM states: IDLE, EXEC, MUL; IDLE->EXEC on start with op!=MUL; IDLE->MUL on start with op=MUL; EXEC->IDLE after one cycle; MUL->IDLE after DATA_W cycles.
REQ-017 On accepted start, operand and op are captured; later operand changes do not affect the operation.
REQ-018 Single-cycle ops: start sampled at edge N; result written to accumulator and flags at edge N+1; done high for the cycle after edge N+1.
REQ-019 MUL: shift-add, one multiplier bit per cycle; low half to accumulator, high half to product_hi; done one cycle after the final iteration edge (start-to-done latency DATA_W+1 cycles).
REQ-020 busy is high from the edge that accepts start until the edge that raises done; busy and done never high in the same cycle.
REQ-021 start while busy is ignored, no queuing.
REQ-022 acc_load while busy is ignored; acc_load in IDLE writes databus to accumulator at the next edge, flags unchanged.
REQ-023 acc_load and start both high in IDLE: acc_load wins, start dropped.
REQ-024 out_enable drives acc_value on databus in any state, including busy; databus is high-impedance when out_enable is low.
REQ-025 Flags: Z = result zero; N = result MSB; ADD C = carry out, V = signed overflow; SUB C = borrow (A<B unsigned), V = signed overflow; SHL/SHR C = bit shifted out, V=0; AND/OR/XOR C=V=0.
REQ-026 MUL flags: Z = full 2*DATA_W product zero; N = accumulator MSB; C = V = (product_hi != 0).
REQ-027 All arithmetic is modulo 2^DATA_W; no saturation.

Reset
REQ-028 Reset forces state IDLE, accumulator 0, flags 0, product_hi 0, busy 0, done 0, databus high-impedance unless out_enable.
REQ-029 Reset during EXEC or MUL aborts the operation; no done pulse issued; reset takes priority over every other input.

Configuration
REQ-030 Macro ALU_MUL_EN defined: MUL op and product_hi behave per REQ-019/REQ-026.
REQ-031 ALU_MUL_EN undefined: op 111 is a NOP taking EXEC path (done after one cycle, accumulator and flags unchanged), product_hi tied 0, no multiplier logic synthesised.

Structure
REQ-032 Package alu_pkg holds op code constants, FSM state encoding and flag bit indices.
REQ-033 Multiplier shall be a sub-module alu_mul_seq (start/done handshake, 2*DATA_W result), instantiated only under ALU_MUL_EN.

Verification
REQ-034 acc_load 0x7F, start ADD with operand 0x01 -> acc 0x80, flags V=1 N=1 C=0 Z=0, done exactly one cycle after acceptance.
REQ-035 acc 0x05, SUB operand 0x05 -> acc 0x00, Z=1 C=0; then SUB operand 0x01 -> acc 0xFF, C=1 N=1.
REQ-036 acc 0x81, SHL -> acc 0x02, C=1; SHR -> acc 0x01, C=0.
REQ-037 ALU_MUL_EN: acc 0x10, MUL operand 0x20 -> acc 0x00, product_hi 0x02, C=V=1, Z=0, done after 9 cycles; second start mid-multiply ignored.
REQ-038 Reset asserted in MUL cycle 4 -> no done, all outputs 0 next cycle; without ALU_MUL_EN op 111 -> done after 1 cycle, acc unchanged.
REQ-039 out_enable high during MUL -> databus equals acc_value each cycle; out_enable low -> databus high-impedance.
